// File: rtl/add_arbiter_if.sv
// Request/response bundle shared by two adder requesters and one result consumer.
// The arbiter connects through the slave modport; the traffic source uses master.
interface add_arbiter_if;
  logic       req0_valid;
  logic [5:0] req0_a;
  logic [5:0] req0_b;
  logic       req0_cin;
  logic       req0_ready;

  logic       req1_valid;
  logic [5:0] req1_a;
  logic [5:0] req1_b;
  logic       req1_cin;
  logic       req1_ready;

  logic       rsp_valid;
  logic [5:0] rsp_sum;
  logic       rsp_cout;
  logic       rsp_id;
  logic       rsp_ready;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_cin,
    output req1_ready,
    output rsp_valid, rsp_sum, rsp_cout, rsp_id,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_cin,
    input  req1_ready,
    input  rsp_valid, rsp_sum, rsp_cout, rsp_id,
    output rsp_ready
  );
endinterface

// File: rtl/add_arbiter.sv
// Two requesters share one 6-bit adder; one registered result slot with 1-cycle latency.
// Optional macro ADD_ARB_SAT_EN saturates the sum to 6'h3F on carry-out.
module add_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  add_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t     state_reg, state_next;
  logic       last_grant_reg, last_grant_next;
  logic [5:0] sum_reg, sum_next;
  logic       cout_reg, cout_next;
  logic       id_reg, id_next;

  logic [1:0] req_valid;
  logic [5:0] req_a [2];
  logic [5:0] req_b [2];
  logic [1:0] req_cin;
  logic [1:0] req_ready;

  logic       sel;
  logic       grant_ok;
  logic       grant;
  logic [6:0] add_full;
  logic [5:0] res_sum;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign req_cin   = {bus.req1_cin, bus.req0_cin};
  assign req_a[0]  = bus.req0_a;
  assign req_a[1]  = bus.req1_a;
  assign req_b[0]  = bus.req0_b;
  assign req_b[1]  = bus.req1_b;

  // On a tie the round-robin winner is whoever did not win last time.
  always_comb begin
    sel = 1'b0;
    if (&req_valid) begin
      sel = RR_EN ? ~last_grant_reg : 1'b0;
    end else begin
      sel = ~req_valid[0];
    end
  end

  assign add_full = {1'b0, req_a[sel]} + {1'b0, req_b[sel]} + {6'd0, req_cin[sel]};

`ifdef ADD_ARB_SAT_EN
  assign res_sum = add_full[6] ? 6'h3F : add_full[5:0];
`else
  assign res_sum = add_full[5:0];
`endif

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    sum_next        = sum_reg;
    cout_next       = cout_reg;
    id_next         = id_reg;
    grant_ok        = 1'b0;

    case (state_reg)
      IDLE:    grant_ok = 1'b1;
      RESP:    grant_ok = bus.rsp_ready;
      default: grant_ok = 1'b0;
    endcase

    grant = !rst && grant_ok && (|req_valid);

    case (state_reg)
      IDLE: begin
        if (grant) state_next = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_next = grant ? RESP : IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (grant) begin
      sum_next        = res_sum;
      cout_next       = add_full[6];
      id_next         = sel;
      last_grant_next = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      sum_reg        <= 6'd0;
      cout_reg       <= 1'b0;
      id_reg         <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      sum_reg        <= sum_next;
      cout_reg       <= cout_next;
      id_reg         <= id_next;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready[gi] = grant && (sel == 1'(gi));
    end
  endgenerate

  assign bus.req0_ready = req_ready[0];
  assign bus.req1_ready = req_ready[1];
  assign bus.rsp_valid  = (state_reg == RESP);
  assign bus.rsp_sum    = sum_reg;
  assign bus.rsp_cout   = cout_reg;
  assign bus.rsp_id     = id_reg;

endmodule

// File: tb/tb_add_arbiter.sv
// Bench for add_arbiter: directed vector table on a round-robin instance, plus random
// traffic on round-robin and fixed-priority instances checked against a transaction model.
module tb_add_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  add_arbiter_if bus_rr();
  add_arbiter_if bus_fp();

  add_arbiter #(.RR_EN(1'b1)) dut_rr (.clk(clk), .rst(rst), .bus(bus_rr));
  add_arbiter #(.RR_EN(1'b0)) dut_fp (.clk(clk), .rst(rst), .bus(bus_fp));

  typedef struct packed {
    logic       rst;
    logic       v0;
    logic [5:0] a0;
    logic [5:0] b0;
    logic       c0;
    logic       v1;
    logic [5:0] a1;
    logic [5:0] b1;
    logic       c1;
    logic       rr;
  } stim_t;

  typedef struct packed {
    stim_t      s;
    logic       r0;
    logic       r1;
    logic       rv;
    logic [5:0] sum;
    logic       cout;
    logic       id;
    logic       cp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Observed outputs of both instances, indexed by instance (0 = round-robin, 1 = fixed).
  logic       act_r0 [2];
  logic       act_r1 [2];
  logic       act_rv [2];
  logic [5:0] act_sum [2];
  logic       act_cout [2];
  logic       act_id [2];
  assign act_r0[0] = bus_rr.req0_ready;  assign act_r0[1] = bus_fp.req0_ready;
  assign act_r1[0] = bus_rr.req1_ready;  assign act_r1[1] = bus_fp.req1_ready;
  assign act_rv[0] = bus_rr.rsp_valid;   assign act_rv[1] = bus_fp.rsp_valid;
  assign act_sum[0] = bus_rr.rsp_sum;    assign act_sum[1] = bus_fp.rsp_sum;
  assign act_cout[0] = bus_rr.rsp_cout;  assign act_cout[1] = bus_fp.rsp_cout;
  assign act_id[0] = bus_rr.rsp_id;      assign act_id[1] = bus_fp.rsp_id;

  // Reference model: one result slot per instance plus who won last time.
  bit         m_init = 1'b0;
  bit         m_held [2];
  logic [5:0] m_sum [2];
  bit         m_cout [2];
  bit         m_id [2];
  bit         m_last [2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ref_add(input logic [5:0] a, input logic [5:0] b, input logic c);
    int total;
    int s;
    int co;
    total = int'(a) + int'(b) + int'(c);
    co = (total > 63) ? 1 : 0;
    s = total % 64;
`ifdef ADD_ARB_SAT_EN
    if (co == 1) s = 63;
`endif
    return {co[0], s[5:0]};
  endfunction

  task automatic model_step(input stim_t s);
    for (int k = 0; k < 2; k++) begin
      bit can;
      bit win;
      bit gnt;
      logic [6:0] res;
      can = !s.rst && (!m_held[k] || s.rr);
      gnt = can && (s.v0 || s.v1);
      if (s.v0 && s.v1) win = (k == 0) ? !m_last[k] : 1'b0;
      else              win = !s.v0;
      if (m_init) begin
        chk($sformatf("m%0d_ready0", k), int'(act_r0[k]), int'(gnt && !win));
        chk($sformatf("m%0d_ready1", k), int'(act_r1[k]), int'(gnt && win));
        chk($sformatf("m%0d_rsp_valid", k), int'(act_rv[k]), int'(m_held[k]));
        if (m_held[k]) begin
          chk($sformatf("m%0d_rsp", k), int'({act_cout[k], act_id[k], act_sum[k]}),
              int'({m_cout[k], m_id[k], m_sum[k]}));
        end
      end
      if (s.rst) begin
        m_held[k] = 1'b0; m_sum[k] = 6'd0; m_cout[k] = 1'b0; m_id[k] = 1'b0; m_last[k] = 1'b1;
      end else if (gnt) begin
        res = win ? ref_add(s.a1, s.b1, s.c1) : ref_add(s.a0, s.b0, s.c0);
        m_held[k] = 1'b1; m_sum[k] = res[5:0]; m_cout[k] = res[6]; m_id[k] = win; m_last[k] = win;
      end else if (m_held[k] && s.rr) begin
        m_held[k] = 1'b0;
      end
    end
    if (s.rst) m_init = 1'b1;
  endtask

  task automatic apply(input stim_t s);
    @(negedge clk);
    rst = s.rst;
    bus_rr.req0_valid = s.v0; bus_rr.req0_a = s.a0; bus_rr.req0_b = s.b0; bus_rr.req0_cin = s.c0;
    bus_rr.req1_valid = s.v1; bus_rr.req1_a = s.a1; bus_rr.req1_b = s.b1; bus_rr.req1_cin = s.c1;
    bus_rr.rsp_ready = s.rr;
    bus_fp.req0_valid = s.v0; bus_fp.req0_a = s.a0; bus_fp.req0_b = s.b0; bus_fp.req0_cin = s.c0;
    bus_fp.req1_valid = s.v1; bus_fp.req1_a = s.a1; bus_fp.req1_b = s.b1; bus_fp.req1_cin = s.c1;
    bus_fp.rsp_ready = s.rr;
    #1;
    model_step(s);
  endtask

  function automatic vec_t mk(
    input logic rst_i, input logic v0, input logic [5:0] a0, input logic [5:0] b0, input logic c0,
    input logic v1, input logic [5:0] a1, input logic [5:0] b1, input logic c1, input logic rr,
    input logic r0, input logic r1, input logic rv, input logic [5:0] sum, input logic cout,
    input logic id, input logic cp);
    vec_t v;
    v.s = '{rst: rst_i, v0: v0, a0: a0, b0: b0, c0: c0, v1: v1, a1: a1, b1: b1, c1: c1, rr: rr};
    v.r0 = r0; v.r1 = r1; v.rv = rv; v.sum = sum; v.cout = cout; v.id = id; v.cp = cp;
    return v;
  endfunction

  vec_t       vecs [19];
  logic [5:0] sat_sum;
  stim_t      st;

  initial begin
`ifdef ADD_ARB_SAT_EN
    sat_sum = 6'd63;
`else
    sat_sum = 6'd1;
`endif
    //            rst v0 a0 b0 c0  v1 a1  b1 c1 rr   r0 r1 rv sum     co id cp
    vecs[0]  = mk(1, 1, 5, 9, 1,  0, 0,  0, 0, 1,   0, 0, 0, 0,      0, 0, 1);
    vecs[1]  = mk(0, 1, 5, 9, 1,  0, 0,  0, 0, 1,   1, 0, 0, 0,      0, 0, 1);
    vecs[2]  = mk(0, 0, 0, 0, 0,  0, 0,  0, 0, 1,   0, 0, 1, 15,     0, 0, 1);
    vecs[3]  = mk(0, 0, 0, 0, 0,  0, 0,  0, 0, 1,   0, 0, 0, 0,      0, 0, 0);
    vecs[4]  = mk(1, 0, 0, 0, 0,  0, 0,  0, 0, 1,   0, 0, 0, 0,      0, 0, 0);
    vecs[5]  = mk(0, 1, 1, 2, 0,  1, 10, 20, 1, 1,  1, 0, 0, 0,      0, 0, 1);
    vecs[6]  = mk(0, 1, 1, 2, 0,  1, 10, 20, 1, 1,  0, 1, 1, 3,      0, 0, 1);
    vecs[7]  = mk(0, 1, 1, 2, 0,  1, 10, 20, 1, 1,  1, 0, 1, 31,     0, 1, 1);
    vecs[8]  = mk(0, 1, 1, 2, 0,  1, 10, 20, 1, 1,  0, 1, 1, 3,      0, 0, 1);
    vecs[9]  = mk(0, 0, 0, 0, 0,  1, 10, 20, 1, 0,  0, 0, 1, 31,     0, 1, 1);
    vecs[10] = mk(0, 0, 0, 0, 0,  1, 10, 20, 1, 0,  0, 0, 1, 31,     0, 1, 1);
    vecs[11] = mk(0, 0, 0, 0, 0,  1, 10, 20, 1, 0,  0, 0, 1, 31,     0, 1, 1);
    vecs[12] = mk(0, 0, 0, 0, 0,  1, 10, 20, 1, 0,  0, 0, 1, 31,     0, 1, 1);
    vecs[13] = mk(0, 0, 0, 0, 0,  1, 10, 20, 1, 1,  0, 1, 1, 31,     0, 1, 1);
    vecs[14] = mk(0, 0, 0, 0, 0,  1, 63, 2,  0, 1,  0, 1, 1, 31,     0, 1, 1);
    vecs[15] = mk(0, 0, 0, 0, 0,  0, 0,  0,  0, 0,  0, 0, 1, sat_sum, 1, 1, 1);
    vecs[16] = mk(1, 1, 5, 9, 1,  0, 0,  0,  0, 0,  0, 0, 1, sat_sum, 1, 1, 1);
    vecs[17] = mk(0, 1, 5, 9, 1,  1, 10, 20, 1, 0,  1, 0, 0, 0,      0, 0, 1);
    vecs[18] = mk(0, 0, 0, 0, 0,  0, 0,  0,  0, 1,  0, 0, 1, 15,     0, 0, 1);

    st = '0;
    st.rst = 1'b1;
    apply(st);
    apply(st);

    for (int i = 0; i < 19; i++) begin
      apply(vecs[i].s);
      chk($sformatf("vec%0d_ready0", i), int'(bus_rr.req0_ready), int'(vecs[i].r0));
      chk($sformatf("vec%0d_ready1", i), int'(bus_rr.req1_ready), int'(vecs[i].r1));
      chk($sformatf("vec%0d_rsp_valid", i), int'(bus_rr.rsp_valid), int'(vecs[i].rv));
      if (vecs[i].cp) begin
        chk($sformatf("vec%0d_rsp_sum", i), int'(bus_rr.rsp_sum), int'(vecs[i].sum));
        chk($sformatf("vec%0d_rsp_cout", i), int'(bus_rr.rsp_cout), int'(vecs[i].cout));
        chk($sformatf("vec%0d_rsp_id", i), int'(bus_rr.rsp_id), int'(vecs[i].id));
      end
      $display("vec %0d: rdy=%0d%0d valid=%0d sum=%0d cout=%0d id=%0d", i,
               bus_rr.req1_ready, bus_rr.req0_ready, bus_rr.rsp_valid,
               bus_rr.rsp_sum, bus_rr.rsp_cout, bus_rr.rsp_id);
    end

    // Fixed priority with both requesters always valid: req0 owns every result.
    st = '0;
    st.rst = 1'b1;
    apply(st);
    for (int i = 0; i < 8; i++) begin
      st = '0;
      st.v0 = 1'b1; st.a0 = 6'($urandom); st.b0 = 6'($urandom); st.c0 = 1'($urandom);
      st.v1 = 1'b1; st.a1 = 6'($urandom); st.b1 = 6'($urandom); st.c1 = 1'($urandom);
      st.rr = 1'b1;
      apply(st);
      chk($sformatf("fp%0d_ready1", i), int'(bus_fp.req1_ready), 0);
      if (i > 0) chk($sformatf("fp%0d_rsp_id", i), int'(bus_fp.rsp_id), 0);
      $display("fp %0d: valid=%0d id=%0d sum=%0d", i, bus_fp.rsp_valid, bus_fp.rsp_id, bus_fp.rsp_sum);
    end

    for (int i = 0; i < 500; i++) begin
      st = '0;
      st.rst = ($urandom_range(0, 39) == 0);
      st.v0 = ($urandom_range(0, 3) != 0);
      st.v1 = ($urandom_range(0, 3) != 0);
      st.a0 = ($urandom_range(0, 7) == 0) ? 6'd63 : 6'($urandom);
      st.b0 = 6'($urandom);
      st.c0 = 1'($urandom);
      st.a1 = ($urandom_range(0, 7) == 0) ? 6'd63 : 6'($urandom);
      st.b1 = 6'($urandom);
      st.c1 = 1'($urandom);
      st.rr = ($urandom_range(0, 2) != 0);
      apply(st);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
